aes_inv_key_schedule: RTL and testbench
=======================================

AES_INV_KEY_SCHEDULE -- requirements
Module: aes_inv_key_schedule

Interface
REQ-001 Parameter NR, default 10, number of AES-128 rounds; only 10 is supported.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  single-cycle request; capture cipher_key and start the forward expansion.
REQ-005 cipher_key  input  128  AES-128 cipher key; w0 = [127:96], w3 = [31:0].
REQ-006 step  input  1  request for the previous round key (index decrements by 1).
REQ-007 round_key  output  128  current round key, registered.
REQ-008 key_idx  output  4  index of the key on round_key (0..10).
REQ-009 key_ready  output  1  high when round_key is valid for decryption use (state READY).
REQ-010 busy  output  1  high during forward expansion (state EXPAND).

Function
REQ-011 The block SHALL have an FSM with states IDLE, EXPAND and READY.
REQ-012 IDLE: load -> key_reg = cipher_key, key_idx = 0, go to EXPAND; step is ignored.
REQ-013 EXPAND: each cycle key_reg = forward_next(key_reg, rcon(key_idx+1)) and key_idx += 1; on the edge where key_idx becomes 10, go to READY.
REQ-014 Latency: key_ready SHALL rise exactly 10 cycles after the edge that samples load, with round_key = round-10 key and key_idx = 10.
REQ-015 Forward step: g = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w4 = w0^g, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6.
REQ-016 READY: step with key_idx > 0 -> next cycle key_reg = inverse_prev(key_reg, rcon(key_idx)) and key_idx -= 1; one key per step, step may be held high every cycle.
REQ-017 Inverse step, from {w4,w5,w6,w7}: w3 = w7^w6, w2 = w6^w5, w1 = w5^w4, w0 = w4 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
REQ-018 Boundary: step in READY with key_idx = 0 SHALL be ignored; round_key stays equal to cipher_key and key_ready stays 1.
REQ-019 Load in any state, including EXPAND and READY, SHALL restart from REQ-012; load and step asserted together -> load wins.
REQ-020 step during EXPAND SHALL be ignored and SHALL NOT be queued.
REQ-021 rcon(k), k = 1..10: 01,02,04,08,10,20,40,80,1b,36; any other index -> 00.
REQ-022 One set of 4 S-boxes SHALL be shared: the S-box input word is w3 in EXPAND and w7^w6 in READY.
REQ-023 round_key SHALL always equal key_reg; key_ready SHALL equal (state == READY); busy SHALL equal (state == EXPAND).

Reset
REQ-024 Asserting rst_n low SHALL immediately give state IDLE, key_reg = 0, key_idx = 0, key_ready = 0 and busy = 0.
REQ-025 Reset during EXPAND or READY SHALL abort the operation; no partial key is retained after reset is released.

Structure
REQ-026 A shared package aes_pkg SHALL hold NR, the rcon table/function and the FSM state encoding.
REQ-027 The S-box SHALL be the existing aes_sbox (8-bit in_byte/out_byte), instantiated 4 times; there are no other sub-modules.
REQ-028 The forward and inverse word logic SHALL be combinational, selected by state, feeding one 128-bit register.

Verification (FIPS-197 key K = 2b7e1516 28aed2a6 abf71588 09cf4f3c)
REQ-029 Load K -> busy high for 10 cycles, then key_ready = 1, key_idx = 10, round_key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-030 One step after REQ-029 -> key_idx = 9, round_key = ac7766f3 19fadc21 28d12941 575c006e.
REQ-031 step held for 12 cycles -> keys 10..0 match the FIPS-197 schedule, final key = K, key_idx holds at 0.
REQ-032 Load K, then load all-zero key 5 cycles later -> 10 cycles after the second load, round_key = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
REQ-033 load and step in the same READY cycle -> restart, key_idx = 0, busy = 1, round_key = new key.
REQ-034 rst_n pulsed low mid-EXPAND and mid-READY -> outputs zero immediately; step while IDLE -> no change.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
//   NR      : number of AES-128 rounds (only 10 is supported)
//   state_t : key-schedule FSM state encoding
//   rcon()  : round constant lookup, k = 1..10, zero otherwise
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] k);
        logic [7:0] rc;
        case (k)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   in_byte  : byte to substitute
//   out_byte : SubBytes(in_byte)
// Computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the
// AES affine transform, instead of a 256-entry table.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] AFFINE_C = 8'h63;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv_byte;

    // x^254 = x^2 * x^4 * ... * x^128
    always_comb begin
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = in_byte;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        inv_byte = acc;
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_affine
            assign out_byte[gi] = inv_byte[gi]
                                ^ inv_byte[(gi + 4) % 8]
                                ^ inv_byte[(gi + 5) % 8]
                                ^ inv_byte[(gi + 6) % 8]
                                ^ inv_byte[(gi + 7) % 8]
                                ^ AFFINE_C[gi];
        end
    endgenerate

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 key schedule that expands forward to the last round key and then
// walks backwards one round key per step, for use by a decryption datapath.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load       : capture cipher_key and start forward expansion (wins over step)
//   cipher_key : AES-128 key, w0 = [127:96] .. w3 = [31:0]
//   step       : move to the previous round key (READY only, ignored at index 0)
//   round_key  : current round key (registered)
//   key_idx    : round index of round_key, 0..10
//   key_ready  : round_key is usable (READY)
//   busy       : forward expansion in progress (EXPAND)
module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] cipher_key,
    input  logic         step,
    output logic [127:0] round_key,
    output logic [3:0]   key_idx,
    output logic         key_ready,
    output logic         busy
);

    import aes_pkg::*;

    state_t         state_reg;
    logic [127:0]   key_reg;
    logic [3:0]     idx_reg;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    sbox_in, sbox_out, g_word;
    logic [3:0]     rc_idx;
    logic [127:0]   fwd_key, inv_key;
    logic           in_ready;

    assign {w0, w1, w2, w3} = key_reg;
    assign in_ready         = (state_reg == ST_READY);

    // In READY key_reg holds {w4,w5,w6,w7}; the word feeding g when going
    // backwards is the recovered w3 = w7 ^ w6, so the S-boxes are shared.
    assign sbox_in = in_ready ? (w3 ^ w2) : w3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_byte  (sbox_in[8*gi +: 8]),
                .out_byte (sbox_out[8*gi +: 8])
            );
        end
    endgenerate

    // Forward uses rcon of the key being produced, inverse the key being undone.
    assign rc_idx = in_ready ? idx_reg : (idx_reg + 4'd1);
    // SubWord commutes with RotWord, so rotate after substitution.
    assign g_word = {sbox_out[23:0], sbox_out[31:24]} ^ {rcon(rc_idx), 24'h000000};

    always_comb begin
        logic [31:0] f4, f5, f6, f7;
        f4      = w0 ^ g_word;
        f5      = w1 ^ f4;
        f6      = w2 ^ f5;
        f7      = w3 ^ f6;
        fwd_key = {f4, f5, f6, f7};
        inv_key = {w0 ^ g_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            key_reg   <= '0;
            idx_reg   <= '0;
        end else if (load) begin
            state_reg <= ST_EXPAND;
            key_reg   <= cipher_key;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_EXPAND: begin
                    key_reg <= fwd_key;
                    idx_reg <= idx_reg + 4'd1;
                    if (idx_reg == 4'(NR - 1)) state_reg <= ST_READY;
                end
                ST_READY: begin
                    if (step && (idx_reg != 4'd0)) begin
                        key_reg <= inv_key;
                        idx_reg <= idx_reg - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign round_key = key_reg;
    assign key_idx   = idx_reg;
    assign key_ready = in_ready;
    assign busy      = (state_reg == ST_EXPAND);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [127:0] cipher_key;
    logic         step;
    logic [127:0] round_key;
    logic [3:0]   key_idx;
    logic         key_ready;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .cipher_key (cipher_key),
        .step       (step),
        .round_key  (round_key),
        .key_idx    (key_idx),
        .key_ready  (key_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_tab [256];
    logic [127:0] sched [11];

    typedef struct {
        int           idx;
        logic [127:0] key;
    } vec_t;
    vec_t fips_tab [11];

    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook 44-word expansion.
    task automatic compute_sched(input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_key"},   round_key, 128'h0);
        check({tag, "_idx"},   128'(key_idx), 128'h0);
        check({tag, "_ready"}, 128'(key_ready), 128'h0);
        check({tag, "_busy"},  128'(busy), 128'h0);
    endtask

    task automatic do_load(input logic [127:0] k);
        cipher_key = k;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!key_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, 128'(key_ready), 128'h1);
    endtask

    initial begin
        logic [127:0] rk;
        int           exp_idx;

        build_sbox();
        fips_tab[0]  = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        fips_tab[1]  = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        fips_tab[2]  = '{2,  128'hf2c295f27a96b9435935807a7359f67f};
        fips_tab[3]  = '{3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        fips_tab[4]  = '{4,  128'hef44a541a8525b7fb671253bdb0bad00};
        fips_tab[5]  = '{5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        fips_tab[6]  = '{6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        fips_tab[7]  = '{7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        fips_tab[8]  = '{8,  128'head27321b58dbad2312bf5607f8d292f};
        fips_tab[9]  = '{9,  128'hac7766f319fadc2128d12941575c006e};
        fips_tab[10] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst_n = 1'b0; load = 1'b0; step = 1'b0; cipher_key = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // step while IDLE does nothing
        step = 1'b1;
        tick();
        step = 1'b0;
        check_zero("idle_step");

        // FIPS key: 10 busy cycles then READY with round-10 key
        do_load(FIPS_K);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("fips_busy_c%0d", i), 128'(busy), 128'h1);
            check($sformatf("fips_idx_c%0d", i), 128'(key_idx), 128'(i));
            tick();
        end
        check("fips_ready", 128'(key_ready), 128'h1);
        check("fips_busy_done", 128'(busy), 128'h0);
        check("fips_idx10", 128'(key_idx), 128'd10);
        check("fips_key10", round_key, fips_tab[10].key);

        // step held 12 cycles: walk the table down, then hold at 0
        exp_idx = 10;
        step = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (exp_idx > 0) exp_idx--;
            check($sformatf("walk%0d_idx", c), 128'(key_idx), 128'(fips_tab[exp_idx].idx));
            check($sformatf("walk%0d_key", c), round_key, fips_tab[exp_idx].key);
            check($sformatf("walk%0d_ready", c), 128'(key_ready), 128'h1);
        end
        step = 1'b0;

        // load and step together in READY: load wins
        rk = {$urandom, $urandom, $urandom, $urandom};
        compute_sched(rk);
        cipher_key = rk; load = 1'b1; step = 1'b1;
        tick();
        load = 1'b0;
        check("ldstep_idx", 128'(key_idx), 128'h0);
        check("ldstep_busy", 128'(busy), 128'h1);
        check("ldstep_key", round_key, rk);

        // step held during expansion is ignored and not queued
        for (int i = 0; i < 9; i++) tick();
        step = 1'b0;
        tick();
        check("expstep_idx", 128'(key_idx), 128'd10);
        check("expstep_key", round_key, sched[10]);
        tick();
        check("expstep_noqueue_idx", 128'(key_idx), 128'd10);

        // reload with zero key mid-expansion
        do_load(FIPS_K);
        repeat (4) tick();
        do_load(128'h0);
        repeat (10) tick();
        check("zero_key10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero_idx10", 128'(key_idx), 128'd10);
        compute_sched(128'h0);
        check("zero_model_key10", round_key, sched[10]);

        // async reset mid-EXPAND
        do_load(FIPS_K);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_zero("rst_expand");
        tick();
        rst_n = 1'b1;
        tick();
        check_zero("rst_expand_after");

        // async reset mid-READY, then step in IDLE
        do_load(FIPS_K);
        wait_ready("rst_ready");
        step = 1'b1;
        repeat (2) tick();
        step = 1'b0;
        check("rst_ready_pre_key", round_key, fips_tab[8].key);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_ready");
        tick();
        rst_n = 1'b1;
        step = 1'b1;
        repeat (2) tick();
        step = 1'b0;
        check_zero("rst_ready_idle_step");

        // random keys with random step patterns
        for (int t = 0; t < 8; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            compute_sched(rk);
            do_load(rk);
            wait_ready($sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_key10", t), round_key, sched[10]);
            exp_idx = 10;
            for (int c = 0; c < 16; c++) begin
                step = 1'($urandom_range(0, 1));
                if (step && exp_idx > 0) exp_idx--;
                tick();
                check($sformatf("rnd%0d_c%0d_idx", t, c), 128'(key_idx), 128'(exp_idx));
                check($sformatf("rnd%0d_c%0d_key", t, c), round_key, sched[exp_idx]);
            end
            step = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
